// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: the writer fills one bank from a pixel stream while the
// reader streams whole lines out of the last completed bank; banks swap between line reads.
module frame_buffer_pingpong #(
  parameter  int PIX_W  = 8,
  parameter  int H_RES  = 220,
  parameter  int V_RES  = 165,
  localparam int ADDR_W = $clog2(H_RES*V_RES),
  localparam int LINE_W = $clog2(V_RES),
  localparam int X_W    = $clog2(H_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_sof,
  output logic              wr_ready,
  output logic              frame_done,
  output logic              frame_avail,
  input  logic              rd_req,
  input  logic [LINE_W-1:0] rd_line,
  output logic              rd_busy,
  output logic              rd_err,
  output logic              px_valid,
  output logic [PIX_W-1:0]  px_data,
  output logic [X_W-1:0]    px_x,
  output logic              px_last,
  output logic              wr_bank
);

  localparam int                DEPTH     = H_RES*V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(H_RES-1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [PIX_W-1:0]  mem [2][DEPTH];
  logic [PIX_W-1:0]  ram_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [X_W-1:0]    x_cnt;
  logic [1:0]        state;
  logic              swap_pending;
  logic              accept;
  logic              wr_last;
  logic              reader_idle;
  logic              swap_now;
  logic              req_any;
  logic              req_held;
  logic [LINE_W-1:0] held_line;
  logic [LINE_W-1:0] req_line;

  assign accept      = wr_valid & wr_ready;
  assign w_addr      = wr_sof ? '0 : wr_ptr;
  assign wr_last     = accept & (w_addr == LAST_ADDR);
  assign wr_ready    = ~swap_pending;
  // The reader only counts as idle once the final pixel has left the output register.
  assign reader_idle = (state == ST_IDLE) & ~px_valid;
  assign rd_busy     = ~reader_idle;
  assign swap_now    = (swap_pending | wr_last) & reader_idle;
  assign req_any     = reader_idle & (rd_req | req_held);
  assign req_line    = req_held ? held_line : rd_line;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][w_addr] <= wr_data;
    ram_q <= mem[~wr_bank][rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      wr_bank      <= 1'b0;
      swap_pending <= 1'b0;
      frame_done   <= 1'b0;
      frame_avail  <= 1'b0;
    end else begin
      frame_done <= wr_last;
      if (accept) wr_ptr <= wr_last ? '0 : w_addr + ADDR_W'(1);
      if (swap_now) begin
        wr_bank      <= ~wr_bank;
        frame_avail  <= 1'b1;
        swap_pending <= 1'b0;
      end else if (wr_last) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_held  <= 1'b0;
      held_line <= '0;
      rd_ptr    <= '0;
      x_cnt     <= '0;
      rd_err    <= 1'b0;
      px_valid  <= 1'b0;
      px_data   <= '0;
      px_x      <= '0;
      px_last   <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          px_valid <= 1'b0;
          px_last  <= 1'b0;
          if (req_any) begin
            // A swap in the same cycle takes priority; the request is replayed next cycle.
            if (swap_now) begin
              if (rd_req && !req_held) begin
                req_held  <= 1'b1;
                held_line <= rd_line;
              end
            end else begin
              req_held <= 1'b0;
              if (!frame_avail || (int'(req_line) >= V_RES)) begin
                rd_err <= 1'b1;
              end else begin
                rd_ptr <= ADDR_W'(req_line) * ADDR_W'(H_RES);
                state  <= ST_FETCH;
              end
            end
          end
        end
        ST_FETCH: begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          x_cnt  <= '0;
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          rd_ptr   <= rd_ptr + ADDR_W'(1);
          x_cnt    <= x_cnt + X_W'(1);
          px_valid <= 1'b1;
          px_data  <= ram_q;
          px_x     <= x_cnt;
          px_last  <= (x_cnt == LAST_X);
          if (x_cnt == LAST_X) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong on a 4x3 frame: directed scenarios plus randomized frames,
// checked against a frame-level model (current partial frame and last completed frame).
module tb_frame_buffer_pingpong;

  localparam int PIX_W = 8;
  localparam int H_RES = 4;
  localparam int V_RES = 3;
  localparam int NPIX  = H_RES*V_RES;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_valid = 1'b0;
  logic [PIX_W-1:0] wr_data = '0;
  logic             wr_sof = 1'b0;
  logic             wr_ready;
  logic             frame_done;
  logic             frame_avail;
  logic             rd_req = 1'b0;
  logic [1:0]       rd_line = '0;
  logic             rd_busy;
  logic             rd_err;
  logic             px_valid;
  logic [PIX_W-1:0] px_data;
  logic [1:0]       px_x;
  logic             px_last;
  logic             wr_bank;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_sof(wr_sof), .wr_ready(wr_ready),
    .frame_done(frame_done), .frame_avail(frame_avail),
    .rd_req(rd_req), .rd_line(rd_line), .rd_busy(rd_busy), .rd_err(rd_err),
    .px_valid(px_valid), .px_data(px_data), .px_x(px_x), .px_last(px_last),
    .wr_bank(wr_bank)
  );

  int checks = 0;
  int failures = 0;

  // Model: the frame being assembled and the last completed frame visible to the reader.
  logic [7:0] cur [NPIX];
  logic [7:0] rdf [NPIX];
  int cur_ptr;
  bit m_avail, m_bank, m_pending;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cur_ptr = 0; m_avail = 0; m_bank = 0; m_pending = 0;
  endtask

  task automatic model_write(input logic [7:0] d, input bit sof, output bit done);
    int p;
    p = sof ? 0 : cur_ptr;
    cur[p] = d;
    done = (p == NPIX-1);
    cur_ptr = done ? 0 : p + 1;
    if (done) m_pending = 1;
  endtask

  task automatic model_swap();
    if (m_pending) begin
      rdf = cur;
      m_avail = 1;
      m_bank = ~m_bank;
      m_pending = 0;
    end
  endtask

  task automatic write_pixel(input logic [7:0] d, input bit sof);
    int guard;
    bit done;
    guard = 0;
    wr_valid = 1; wr_data = d; wr_sof = sof;
    checkOutput("wr_ready", {31'b0, wr_ready}, {31'b0, ~m_pending});
    while (wr_ready !== 1'b1 && guard < 40) begin tick(); guard++; end
    checkOutput("wr_ready_timeout", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_valid = 0; wr_sof = 0;
    model_write(d, sof, done);
    if (done) model_swap();
    checkOutput("frame_done", {31'b0, frame_done}, {31'b0, done});
    checkOutput("wr_bank", {31'b0, wr_bank}, {31'b0, m_bank});
    checkOutput("frame_avail", {31'b0, frame_avail}, {31'b0, m_avail});
  endtask

  // Called just after the edge that sampled the request; lat = edges until first pixel.
  task automatic collect_line(input int line, input int lat);
    for (int k = 1; k < lat; k++) begin
      checkOutput("pre_px_valid", {31'b0, px_valid}, 32'd0);
      tick();
    end
    for (int x = 0; x < H_RES; x++) begin
      tick();
      checkOutput("px_valid", {31'b0, px_valid}, 32'd1);
      checkOutput("px_data", {24'b0, px_data}, {24'b0, rdf[line*H_RES + x]});
      checkOutput("px_x", {30'b0, px_x}, 32'(x));
      checkOutput("px_last", {31'b0, px_last}, {31'b0, (x == H_RES-1)});
    end
    tick();
    checkOutput("post_px_valid", {31'b0, px_valid}, 32'd0);
    checkOutput("post_rd_busy", {31'b0, rd_busy}, 32'd0);
    checkOutput("px_data_hold", {24'b0, px_data}, {24'b0, rdf[line*H_RES + H_RES-1]});
  endtask

  task automatic issue_read(input int line);
    bit err;
    err = !m_avail || (line >= V_RES);
    rd_req = 1; rd_line = 2'(line);
    tick();
    rd_req = 0;
    checkOutput("rd_err", {31'b0, rd_err}, {31'b0, err});
    if (err) begin
      tick();
      checkOutput("rd_err_pulse", {31'b0, rd_err}, 32'd0);
      checkOutput("err_px_valid", {31'b0, px_valid}, 32'd0);
      checkOutput("err_rd_busy", {31'b0, rd_busy}, 32'd0);
    end else begin
      collect_line(line, 2);
    end
  endtask

  task automatic applyStimulus();
    bit done;
    int partial;
    logic [7:0] d;

    // Reset values
    model_reset();
    reset = 0;
    repeat (3) tick();
    checkOutput("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    checkOutput("rst_wr_bank", {31'b0, wr_bank}, 32'd0);
    checkOutput("rst_frame_avail", {31'b0, frame_avail}, 32'd0);
    checkOutput("rst_rd_busy", {31'b0, rd_busy}, 32'd0);
    checkOutput("rst_px_valid", {31'b0, px_valid}, 32'd0);
    reset = 1;
    tick();

    // Read before any frame is rejected
    issue_read(0);

    // First frame, then line 1 and an out-of-range line
    for (int i = 0; i < NPIX; i++) write_pixel(8'(i + 1), 0);
    issue_read(1);
    issue_read(3);

    // Second frame completes while line 2 of the first is streaming
    for (int i = 0; i < NPIX-1; i++) write_pixel(8'(8'h11 + i), 0);
    rd_req = 1; rd_line = 2'd2;
    tick();
    rd_req = 0;
    checkOutput("t4_rd_err", {31'b0, rd_err}, 32'd0);
    tick();
    checkOutput("t4_pre_valid", {31'b0, px_valid}, 32'd0);
    wr_valid = 1; wr_data = 8'h1C;
    checkOutput("t4_wr_ready", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_valid = 0;
    model_write(8'h1C, 0, done);
    checkOutput("t4_frame_done", {31'b0, frame_done}, {31'b0, done});
    checkOutput("t4_bank_held", {31'b0, wr_bank}, {31'b0, m_bank});
    for (int x = 0; x < H_RES; x++) begin
      if (x > 0) tick();
      checkOutput("t4_px_data", {24'b0, px_data}, {24'b0, rdf[2*H_RES + x]});
      checkOutput("t4_px_last", {31'b0, px_last}, {31'b0, (x == H_RES-1)});
      checkOutput("t4_wr_ready_low", {31'b0, wr_ready}, {31'b0, ~m_pending});
    end
    tick();
    checkOutput("t4_post_valid", {31'b0, px_valid}, 32'd0);
    checkOutput("t4_post_busy", {31'b0, rd_busy}, 32'd0);
    tick();
    model_swap();
    checkOutput("t4_swap_ready", {31'b0, wr_ready}, 32'd1);
    checkOutput("t4_swap_bank", {31'b0, wr_bank}, {31'b0, m_bank});
    checkOutput("t4_swap_avail", {31'b0, frame_avail}, {31'b0, m_avail});
    issue_read(0);

    // Mid-frame resync discards the partial frame
    for (int i = 0; i < 5; i++) write_pixel(8'(8'h21 + i), 0);
    write_pixel(8'hAA, 1);
    for (int i = 0; i < NPIX-1; i++) write_pixel(8'(8'h31 + i), 0);
    issue_read(0);

    // Read request coinciding with a swap is replayed one cycle later from the new bank
    for (int i = 0; i < NPIX-1; i++) write_pixel(8'($urandom), (i == 0));
    d = 8'($urandom);
    wr_valid = 1; wr_data = d; rd_req = 1; rd_line = 2'd1;
    tick();
    wr_valid = 0; rd_req = 0;
    model_write(d, 0, done);
    model_swap();
    checkOutput("sim_frame_done", {31'b0, frame_done}, {31'b0, done});
    checkOutput("sim_rd_err", {31'b0, rd_err}, 32'd0);
    checkOutput("sim_wr_bank", {31'b0, wr_bank}, {31'b0, m_bank});
    collect_line(1, 3);

    // Randomized frames with partial prefixes, idle gaps and random line reads
    for (int f = 0; f < 4; f++) begin
      partial = int'($urandom_range(0, 6));
      for (int i = 0; i < partial; i++) write_pixel(8'($urandom), 0);
      for (int i = 0; i < NPIX; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        write_pixel(8'($urandom), (i == 0));
      end
      repeat (2) issue_read(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a readout and a partial frame
    for (int i = 0; i < 5; i++) write_pixel(8'($urandom), 0);
    rd_req = 1; rd_line = 2'd0;
    tick();
    rd_req = 0;
    repeat (2) tick();
    reset = 0;
    #1;
    model_reset();
    checkOutput("mid_rst_px_valid", {31'b0, px_valid}, 32'd0);
    checkOutput("mid_rst_rd_busy", {31'b0, rd_busy}, 32'd0);
    checkOutput("mid_rst_avail", {31'b0, frame_avail}, 32'd0);
    checkOutput("mid_rst_bank", {31'b0, wr_bank}, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, wr_ready}, 32'd1);
    tick();
    reset = 1;
    tick();
    issue_read(1);
    for (int i = 0; i < NPIX; i++) write_pixel(8'($urandom), 0);
    issue_read(2);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
